// File: rtl/i2c_reg_target.sv
// I2C target exposing an NREGS x 8-bit register bank addressed through a pointer byte.
// Define I2C_READBACK_EN to support the read direction; otherwise read addresses are NACKed.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         NREGS       = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic [NREGS*8-1:0]       regs_out,
  output logic                     wr_strobe,
  output logic [$clog2(NREGS)-1:0] wr_idx,
  output logic                     busy
);
  localparam int PW = $clog2(NREGS);

  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, PTR = 4'd3, PTR_ACK = 4'd4,
    WDATA = 4'd5, WDATA_ACK = 4'd6, RDATA = 4'd7, RACK = 4'd8
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, start_s, stop_s, rise_s, fall_s, last_s, in_range_s;
  logic [7:0]             byte_s;
  logic [PW-1:0]          ptr_inc_s;
  logic [2:0]             cnt_q, cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic                   phase_q, phase_d, oe_q, oe_d, strobe_q, strobe_d, busy_q;
  logic [PW-1:0]          ptr_q, ptr_d, idx_q, idx_d;
  logic [NREGS*8-1:0]     regs_q, regs_d;
`ifdef I2C_READBACK_EN
  logic                   rw_q, rw_d;
  logic [6:0]             tx_q, tx_d;
  logic [7:0]             cur_reg_s;
  assign cur_reg_s = regs_q[{ptr_q, 3'b000} +: 8];
`endif

  // Synchronisers idle high so reset never manufactures a bus condition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rise_s     = scl_s & ~scl_prev_q;
  assign fall_s     = ~scl_s & scl_prev_q;
  assign last_s     = (cnt_q == 3'd7);
  assign byte_s     = {shift_q, sda_s};
  assign in_range_s = ({1'b0, byte_s} < 9'(NREGS));
  assign ptr_inc_s  = (ptr_q == PW'(NREGS - 1)) ? {PW{1'b0}} : ptr_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; bus conditions override any bit event in the same cycle
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = ADDR;
    end else if (stop_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        ADDR: begin
          if (rise_s && last_s) begin
            if (byte_s == {DEV_ADDR, 1'b0}) state_d = ADDR_ACK;
`ifdef I2C_READBACK_EN
            else if (byte_s == {DEV_ADDR, 1'b1}) state_d = ADDR_ACK;
`endif
            else state_d = IDLE;
          end else begin
            state_d = ADDR;
          end
        end
`ifdef I2C_READBACK_EN
        ADDR_ACK:  state_d = (fall_s && phase_q) ? (rw_q ? RDATA : PTR) : ADDR_ACK;
        RDATA:     state_d = (fall_s && last_s) ? RACK : RDATA;
        RACK: begin
          if (rise_s && !phase_q) state_d = sda_s ? IDLE : RACK;
          else if (fall_s && phase_q) state_d = RDATA;
          else state_d = RACK;
        end
`else
        ADDR_ACK:  state_d = (fall_s && phase_q) ? PTR : ADDR_ACK;
`endif
        PTR:       state_d = (rise_s && last_s) ? (in_range_s ? PTR_ACK : IDLE) : PTR;
        PTR_ACK:   state_d = (fall_s && phase_q) ? WDATA : PTR_ACK;
        WDATA:     state_d = (rise_s && last_s) ? WDATA_ACK : WDATA;
        WDATA_ACK: state_d = (fall_s && phase_q) ? WDATA : WDATA_ACK;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values; phase_q marks the second half of an ACK slot
  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    phase_d  = phase_q;
    oe_d     = oe_q;
    ptr_d    = ptr_q;
    regs_d   = regs_q;
    strobe_d = 1'b0;
    idx_d    = idx_q;
`ifdef I2C_READBACK_EN
    rw_d     = rw_q;
    tx_d     = tx_q;
`endif
    if (start_s || stop_s) begin
      cnt_d   = 3'd0;
      phase_d = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (rise_s) begin
            shift_d = byte_s[6:0];
            cnt_d   = cnt_q + 3'd1;
            phase_d = 1'b0;
            if (last_s && state_q == PTR && in_range_s) ptr_d = byte_s[PW-1:0];
            else ptr_d = ptr_q;
            if (last_s && state_q == WDATA) begin
              regs_d[{ptr_q, 3'b000} +: 8] = byte_s;
              strobe_d = 1'b1;
              idx_d    = ptr_q;
              ptr_d    = ptr_inc_s;
            end
`ifdef I2C_READBACK_EN
            if (last_s && state_q == ADDR) rw_d = sda_s;
            else rw_d = rw_q;
`endif
          end else begin
            cnt_d = cnt_q;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (fall_s && !phase_q) begin
            oe_d    = 1'b1;
            phase_d = 1'b1;
          end else if (fall_s) begin
            oe_d    = 1'b0;
            phase_d = 1'b0;
            cnt_d   = 3'd0;
`ifdef I2C_READBACK_EN
            if (state_q == ADDR_ACK && rw_q) begin
              oe_d = ~cur_reg_s[7];
              tx_d = cur_reg_s[6:0];
            end else begin
              tx_d = tx_q;
            end
`endif
          end else begin
            oe_d = oe_q;
          end
        end
`ifdef I2C_READBACK_EN
        RDATA: begin
          if (fall_s && last_s) begin
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            phase_d = 1'b0;
          end else if (fall_s) begin
            oe_d  = ~tx_q[6];
            tx_d  = {tx_q[5:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
          end else begin
            oe_d = oe_q;
          end
        end
        RACK: begin
          if (rise_s && !phase_q) begin
            oe_d = 1'b0;
            if (!sda_s) begin
              ptr_d   = ptr_inc_s;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
            end
          end else if (fall_s && phase_q) begin
            oe_d    = ~cur_reg_s[7];
            tx_d    = cur_reg_s[6:0];
            cnt_d   = 3'd0;
            phase_d = 1'b0;
          end else begin
            oe_d = oe_q;
          end
        end
`endif
        default: oe_d = 1'b0;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 3'd0;
      shift_q  <= 7'd0;
      phase_q  <= 1'b0;
      oe_q     <= 1'b0;
      ptr_q    <= {PW{1'b0}};
      regs_q   <= {(NREGS*8){1'b0}};
      strobe_q <= 1'b0;
      idx_q    <= {PW{1'b0}};
      busy_q   <= 1'b0;
`ifdef I2C_READBACK_EN
      rw_q     <= 1'b0;
      tx_q     <= 7'd0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      phase_q  <= phase_d;
      oe_q     <= oe_d;
      ptr_q    <= ptr_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      busy_q   <= (state_d != IDLE);
`ifdef I2C_READBACK_EN
      rw_q     <= rw_d;
      tx_q     <= tx_d;
`endif
    end
  end

  assign sda_oe    = oe_q;
  assign regs_out  = regs_q;
  assign wr_strobe = strobe_q;
  assign wr_idx    = idx_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged I2C master on a wired-AND SDA,
// hand-computed expectations; read-direction steps follow I2C_READBACK_EN.
module tb_i2c_reg_target;
  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst_n, scl, sda_m;
  logic        sda_bus, sda_oe, wr_strobe, busy;
  logic [63:0] regs_out;
  logic [2:0]  wr_idx;

  int nvec = 0, nerr = 0;
  int n_strobe = 0, run = 0, max_run = 0;
  logic [2:0] idx_log [$];
  logic       a;
  logic [7:0] b;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_reg_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      n_strobe++;
      idx_log.push_back(wr_idx);
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic half();  repeat (Q) @(negedge clk); endtask
  task automatic hold();  repeat (2) @(negedge clk); endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl = 1'b1; half();
    sda_m = 1'b0; half();
    scl = 1'b0; hold();
  endtask

  task automatic i2c_rep_start();
    sda_m = 1'b1; half();
    scl = 1'b1; half();
    sda_m = 1'b0; half();
    scl = 1'b0; hold();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; half();
    scl = 1'b1; half();
    sda_m = 1'b1; half();
  endtask

  task automatic write_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = v[i]; half();
      scl = 1'b1; half();
      scl = 1'b0; hold();
    end
  endtask

  task automatic ack_slot(output logic ack);
    sda_m = 1'b1; half();
    scl = 1'b1; half();
    ack = sda_bus;
    scl = 1'b0; hold();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    write_bits(v, 8);
    ack_slot(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic mack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      half();
      scl = 1'b1; half();
      v[i] = sda_bus;
      scl = 1'b0; hold();
    end
    sda_m = mack; half();
    scl = 1'b1; half();
    scl = 1'b0; hold();
    sda_m = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", {63'd0, sda_oe}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_regs", regs_out, 64'd0);
    chk("rst_strobe_idx", {60'd0, wr_strobe, wr_idx}, 64'd0);
    rst_n = 1'b1; half();

    // Two-byte write at pointer 3
    i2c_start();
    write_byte(8'h54, a); chk("w1_addr_ack", {63'd0, a}, 64'd0);
    chk("w1_busy", {63'd0, busy}, 64'd1);
    write_byte(8'h03, a); chk("w1_ptr_ack", {63'd0, a}, 64'd0);
    write_byte(8'hA5, a); chk("w1_d0_ack", {63'd0, a}, 64'd0);
    write_byte(8'h5A, a); chk("w1_d1_ack", {63'd0, a}, 64'd0);
    i2c_stop();
    chk("w1_busy_after_stop", {63'd0, busy}, 64'd0);
    chk("w1_regs", regs_out, 64'h0000_005A_A500_0000);
    chk("w1_strobes", 64'(n_strobe), 64'd2);
    chk("w1_idx0", (idx_log.size() > 0) ? {61'd0, idx_log[0]} : 64'hX, 64'd3);
    chk("w1_idx1", (idx_log.size() > 1) ? {61'd0, idx_log[1]} : 64'hX, 64'd4);

    // Pointer wrap 7 -> 0
    i2c_start();
    write_byte(8'h54, a);
    write_byte(8'h07, a);
    write_byte(8'h11, a);
    write_byte(8'h22, a); chk("wrap_d1_ack", {63'd0, a}, 64'd0);
    i2c_stop();
    chk("wrap_regs", regs_out, 64'h1100_005A_A500_0022);
    chk("wrap_idx", (idx_log.size() > 3) ? {58'd0, idx_log[2], idx_log[3]} : 64'hX, 64'h38);

    // Preload regs 1/2 for the read test
    i2c_start();
    write_byte(8'h54, a);
    write_byte(8'h01, a);
    write_byte(8'h3C, a);
    write_byte(8'hC3, a);
    i2c_stop();
    chk("pre_regs", regs_out, 64'h1100_005A_A5C3_3C22);

    // Pointer set, repeated START, read address
    i2c_start();
    write_byte(8'h54, a);
    write_byte(8'h01, a);
    i2c_rep_start();
    write_byte(8'h55, a);
`ifdef I2C_READBACK_EN
    chk("rd_addr_ack", {63'd0, a}, 64'd0);
    read_byte(b, 1'b0); chk("rd_byte0", {56'd0, b}, 64'h3C);
    read_byte(b, 1'b1); chk("rd_byte1", {56'd0, b}, 64'hC3);
    half();
    chk("rd_nack_release", {63'd0, sda_oe}, 64'd0);
    chk("rd_nack_idle", {63'd0, busy}, 64'd0);
`else
    chk("rd_addr_nack", {63'd0, a}, 64'd1);
    chk("rd_nack_idle", {63'd0, busy}, 64'd0);
`endif
    i2c_stop();

    // Foreign address, then out-of-range pointer
    i2c_start();
    write_byte(8'h56, a); chk("bad_addr_nack", {63'd0, a}, 64'd1);
    chk("bad_addr_busy", {63'd0, busy}, 64'd0);
    i2c_stop();
    i2c_start();
    write_byte(8'h54, a); chk("bad_ptr_addr_ack", {63'd0, a}, 64'd0);
    write_byte(8'h09, a); chk("bad_ptr_nack", {63'd0, a}, 64'd1);
    chk("bad_ptr_busy", {63'd0, busy}, 64'd0);
    write_byte(8'h77, a); chk("bad_ptr_data_nack", {63'd0, a}, 64'd1);
    i2c_stop();
    chk("bad_regs", regs_out, 64'h1100_005A_A5C3_3C22);
    chk("bad_strobes", 64'(n_strobe), 64'd6);

    // STOP after a partial byte
    i2c_start();
    write_byte(8'h54, a);
    write_byte(8'h05, a);
    write_bits(8'hF0, 4);
    i2c_stop();
    chk("partial_strobes", 64'(n_strobe), 64'd6);
    chk("partial_regs", regs_out, 64'h1100_005A_A5C3_3C22);

    // Reset while the target drives an ACK
    i2c_start();
    write_byte(8'h54, a);
    write_bits(8'h00, 8);
    sda_m = 1'b1; half();
    chk("mid_ack_drive", {63'd0, sda_oe}, 64'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_oe", {63'd0, sda_oe}, 64'd0);
    chk("mid_rst_regs", regs_out, 64'd0);
    chk("mid_rst_busy_idx", {60'd0, busy, wr_idx}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    scl = 1'b1; half();
    scl = 1'b0; hold();
    write_byte(8'h99, a); chk("post_rst_ignored", {63'd0, a}, 64'd1);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_strobes", 64'(n_strobe), 64'd6);
    i2c_stop();
    i2c_start();
    write_byte(8'h54, a); chk("post_rst_addr_ack", {63'd0, a}, 64'd0);
    write_byte(8'h02, a);
    write_byte(8'h66, a);
    i2c_stop();
    chk("post_rst_regs", regs_out, 64'h0000_0000_0066_0000);
    chk("post_rst_strobes2", 64'(n_strobe), 64'd7);
    chk("strobe_width", 64'(max_run), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
